// File: rtl/ex_stage_mdu.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative MUL/DIV unit,
// and the EX/MEM pipeline register.
module ex_stage_mdu #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MDU_EN     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [REG_ADDR_W-1:0] rd_add_i,
  input  logic                  regwrite_i,
  input  logic                  rd_mem_i,
  input  logic                  wr_mem_i,
  input  logic [2:0]            mem_op_i,
  input  logic [1:0]            sel_to_reg_i,
  input  logic [1:0]            sel_a_i,
  input  logic                  sel_b_i,
  input  logic [1:0]            fwd_a_i,
  input  logic [1:0]            fwd_b_i,
  input  logic [DATA_WIDTH-1:0] mem_fwd_i,
  input  logic [DATA_WIDTH-1:0] wb_fwd_i,
  input  logic [3:0]            alu_op_i,
  input  logic                  md_en_i,
  input  logic [1:0]            md_op_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_pc_o,
  output logic [DATA_WIDTH-1:0] out_result_o,
  output logic [DATA_WIDTH-1:0] out_rs2_data_o,
  output logic [DATA_WIDTH-1:0] out_pc_dest_o,
  output logic                  out_zero_o,
  output logic [REG_ADDR_W-1:0] out_rd_add_o,
  output logic                  out_regwrite_o,
  output logic                  out_rd_mem_o,
  output logic                  out_wr_mem_o,
  output logic [2:0]            out_mem_op_o,
  output logic [1:0]            out_sel_to_reg_o
);

  localparam int unsigned SHW  = $clog2(DATA_WIDTH);
  localparam int unsigned CNTW = SHW;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e                  state_q;
  logic [CNTW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0]   hi_q, lo_q, b_q;
  logic [1:0]              md_op_q;
  logic [DATA_WIDTH-1:0]   cap_pc_q, cap_rs2_q, cap_pcd_q;
  logic [REG_ADDR_W-1:0]   cap_rd_q;
  logic                    cap_rw_q, cap_rdm_q, cap_wrm_q;
  logic [2:0]              cap_memop_q;
  logic [1:0]              cap_sel_q;

  logic [DATA_WIDTH-1:0]   fwd_a, fwd_b, op_a, op_b, alu_res, pc_dest, md_res;
  logic [DATA_WIDTH:0]     mul_sum, div_shift, div_diff;
  logic                    accept, md_go;

  assign in_ready_o = (state_q == IDLE);
  assign accept     = (state_q == IDLE) && in_valid_i && !flush;
  assign md_go      = accept && md_en_i && (MDU_EN != 0);
  assign pc_dest    = pc_i + imm_i;

  // Forwarding and operand selection
  always_comb begin
    fwd_a = rs1_data_i;
    fwd_b = rs2_data_i;
    case (fwd_a_i)
      2'b01:   fwd_a = mem_fwd_i;
      2'b10:   fwd_a = wb_fwd_i;
      default: fwd_a = rs1_data_i;
    endcase
    case (fwd_b_i)
      2'b01:   fwd_b = mem_fwd_i;
      2'b10:   fwd_b = wb_fwd_i;
      default: fwd_b = rs2_data_i;
    endcase
    case (sel_a_i)
      2'b00:   op_a = fwd_a;
      2'b01:   op_a = pc_i;
      default: op_a = '0;
    endcase
    op_b = sel_b_i ? imm_i : fwd_b;
  end

  // Single-cycle ALU
  always_comb begin
    alu_res = '0;
    case (alu_op_i)
      4'd0: alu_res = op_a + op_b;
      4'd1: alu_res = op_a - op_b;
      4'd2: alu_res = op_a & op_b;
      4'd3: alu_res = op_a | op_b;
      4'd4: alu_res = op_a ^ op_b;
      4'd5: alu_res = op_a << op_b[SHW-1:0];
      4'd6: alu_res = op_a >> op_b[SHW-1:0];
      4'd7: alu_res = DATA_WIDTH'($signed(op_a) >>> op_b[SHW-1:0]);
      4'd8: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd9: alu_res = {{(DATA_WIDTH-1){1'b0}}, (op_a < op_b)};
      default: alu_res = '0;
    endcase
  end

  // One MDU iteration: shift-add multiply or restoring divide step
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[DATA_WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    md_res    = md_op_q[0] ? hi_q : lo_q;
  end

  // MDU control FSM and iteration datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      b_q         <= '0;
      md_op_q     <= '0;
      cap_pc_q    <= '0;
      cap_rs2_q   <= '0;
      cap_pcd_q   <= '0;
      cap_rd_q    <= '0;
      cap_rw_q    <= 1'b0;
      cap_rdm_q   <= 1'b0;
      cap_wrm_q   <= 1'b0;
      cap_memop_q <= '0;
      cap_sel_q   <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (md_go) begin
          state_q     <= BUSY;
          cnt_q       <= '0;
          hi_q        <= '0;
          lo_q        <= op_a;
          b_q         <= op_b;
          md_op_q     <= md_op_i;
          cap_pc_q    <= pc_i;
          cap_rs2_q   <= fwd_b;
          cap_pcd_q   <= pc_dest;
          cap_rd_q    <= rd_add_i;
          cap_rw_q    <= regwrite_i;
          cap_rdm_q   <= rd_mem_i;
          cap_wrm_q   <= wr_mem_i;
          cap_memop_q <= mem_op_i;
          cap_sel_q   <= sel_to_reg_i;
        end
        BUSY: begin
          if (!md_op_q[1]) begin
            hi_q <= mul_sum[DATA_WIDTH:1];
            lo_q <= {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
          end else if (!div_diff[DATA_WIDTH]) begin
            hi_q <= div_diff[DATA_WIDTH-1:0];
            lo_q <= {lo_q[DATA_WIDTH-2:0], 1'b1};
          end else begin
            hi_q <= div_shift[DATA_WIDTH-1:0];
            lo_q <= {lo_q[DATA_WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(DATA_WIDTH-1)) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // EX/MEM pipeline register; bubble unless an ALU result or MDU result lands
  always_ff @(posedge clk) begin
    if (rst) begin
      out_pc_o <= '0;
    end
    if (rst || flush || !((accept && !md_go) || (state_q == DONE))) begin
      out_valid_o      <= 1'b0;
      out_result_o     <= '0;
      out_rs2_data_o   <= '0;
      out_pc_dest_o    <= '0;
      out_zero_o       <= 1'b0;
      out_rd_add_o     <= '0;
      out_regwrite_o   <= 1'b0;
      out_rd_mem_o     <= 1'b0;
      out_wr_mem_o     <= 1'b0;
      out_mem_op_o     <= '0;
      out_sel_to_reg_o <= '0;
    end else if (state_q == DONE) begin
      out_valid_o      <= 1'b1;
      out_pc_o         <= cap_pc_q;
      out_result_o     <= md_res;
      out_rs2_data_o   <= cap_rs2_q;
      out_pc_dest_o    <= cap_pcd_q;
      out_zero_o       <= (md_res == '0);
      out_rd_add_o     <= cap_rd_q;
      out_regwrite_o   <= cap_rw_q;
      out_rd_mem_o     <= cap_rdm_q;
      out_wr_mem_o     <= cap_wrm_q;
      out_mem_op_o     <= cap_memop_q;
      out_sel_to_reg_o <= cap_sel_q;
    end else begin
      out_valid_o      <= 1'b1;
      out_pc_o         <= pc_i;
      out_result_o     <= alu_res;
      out_rs2_data_o   <= fwd_b;
      out_pc_dest_o    <= pc_dest;
      out_zero_o       <= (alu_res == '0);
      out_rd_add_o     <= rd_add_i;
      out_regwrite_o   <= regwrite_i;
      out_rd_mem_o     <= rd_mem_i;
      out_wr_mem_o     <= wr_mem_i;
      out_mem_op_o     <= mem_op_i;
      out_sel_to_reg_o <= sel_to_reg_i;
    end
  end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu: ALU ops, forwarding, MDU latency, flush, reset.
module tb_ex_stage_mdu;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid_i, in_ready_o;
  logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i, mem_fwd_i, wb_fwd_i;
  logic [4:0]  rd_add_i;
  logic        regwrite_i, rd_mem_i, wr_mem_i, sel_b_i, md_en_i;
  logic [2:0]  mem_op_i;
  logic [1:0]  sel_to_reg_i, sel_a_i, fwd_a_i, fwd_b_i, md_op_i;
  logic [3:0]  alu_op_i;
  logic        out_valid_o, out_zero_o, out_regwrite_o, out_rd_mem_o, out_wr_mem_o;
  logic [31:0] out_pc_o, out_result_o, out_rs2_data_o, out_pc_dest_o;
  logic [4:0]  out_rd_add_o;
  logic [2:0]  out_mem_op_o;
  logic [1:0]  out_sel_to_reg_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_stage_mdu dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .rd_add_i(rd_add_i), .regwrite_i(regwrite_i), .rd_mem_i(rd_mem_i), .wr_mem_i(wr_mem_i),
    .mem_op_i(mem_op_i), .sel_to_reg_i(sel_to_reg_i), .sel_a_i(sel_a_i), .sel_b_i(sel_b_i),
    .fwd_a_i(fwd_a_i), .fwd_b_i(fwd_b_i), .mem_fwd_i(mem_fwd_i), .wb_fwd_i(wb_fwd_i),
    .alu_op_i(alu_op_i), .md_en_i(md_en_i), .md_op_i(md_op_i),
    .out_valid_o(out_valid_o), .out_pc_o(out_pc_o), .out_result_o(out_result_o),
    .out_rs2_data_o(out_rs2_data_o), .out_pc_dest_o(out_pc_dest_o), .out_zero_o(out_zero_o),
    .out_rd_add_o(out_rd_add_o), .out_regwrite_o(out_regwrite_o), .out_rd_mem_o(out_rd_mem_o),
    .out_wr_mem_o(out_wr_mem_o), .out_mem_op_o(out_mem_op_o), .out_sel_to_reg_o(out_sel_to_reg_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in();
    in_valid_i = 1'b0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0; imm_i = '0;
    mem_fwd_i = '0; wb_fwd_i = '0; rd_add_i = '0; regwrite_i = 1'b0; rd_mem_i = 1'b0;
    wr_mem_i = 1'b0; mem_op_i = '0; sel_to_reg_i = '0; sel_a_i = '0; sel_b_i = 1'b0;
    fwd_a_i = '0; fwd_b_i = '0; alu_op_i = '0; md_en_i = 1'b0; md_op_i = '0;
  endtask

  task automatic drive_alu(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                           input logic use_imm, input logic [3:0] op, input logic [4:0] rd);
    clear_in();
    in_valid_i = 1'b1; pc_i = pc; rs1_data_i = a; regwrite_i = 1'b1; rd_add_i = rd;
    alu_op_i = op;
    if (use_imm) begin sel_b_i = 1'b1; imm_i = b; end
    else rs2_data_i = b;
  endtask

  task automatic start_mdu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    clear_in();
    in_valid_i = 1'b1; pc_i = 32'h200; rs1_data_i = a; rs2_data_i = b; imm_i = 32'h10;
    md_en_i = 1'b1; md_op_i = op; rd_add_i = 5'd9; regwrite_i = 1'b1;
    tick();
    clear_in();
  endtask

  task automatic run_mdu(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int vseen = 0;
    int rseen = 0;
    start_mdu(op, a, b);
    chk({tag, "_acc_ready"}, 32'(in_ready_o), 32'd0);
    chk({tag, "_acc_valid"}, 32'(out_valid_o), 32'd0);
    repeat (32) begin
      tick();
      if (out_valid_o) vseen++;
      if (in_ready_o) rseen++;
    end
    chk({tag, "_busy_valid"}, 32'(vseen), 32'd0);
    chk({tag, "_busy_ready"}, 32'(rseen), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(out_valid_o), 32'd1);
    chk({tag, "_result"}, out_result_o, exp);
    chk({tag, "_rd"}, 32'(out_rd_add_o), 32'd9);
    chk({tag, "_pcdest"}, out_pc_dest_o, 32'h210);
    chk({tag, "_ready"}, 32'(in_ready_o), 32'd1);
  endtask

  initial begin
    int vseen;
    clear_in();
    rst = 1'b1; flush = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_pc", out_pc_o, 32'd0);
    chk("rst_result", out_result_o, 32'd0);
    chk("rst_ready", 32'(in_ready_o), 32'd1);

    // ADD with rs1 forwarded from MEM plus immediate
    drive_alu(32'h100, 32'd5, 32'd3, 1'b1, 4'd0, 5'd7);
    fwd_a_i = 2'b01; mem_fwd_i = 32'h10;
    tick();
    chk("add_valid", 32'(out_valid_o), 32'd1);
    chk("add_result", out_result_o, 32'h13);
    chk("add_zero", 32'(out_zero_o), 32'd0);
    chk("add_rd", 32'(out_rd_add_o), 32'd7);
    chk("add_pc", out_pc_o, 32'h100);
    chk("add_pcdest", out_pc_dest_o, 32'h103);

    drive_alu(32'h104, 32'd7, 32'd7, 1'b0, 4'd1, 5'd1);
    tick();
    chk("sub_result", out_result_o, 32'd0);
    chk("sub_zero", 32'(out_zero_o), 32'd1);

    drive_alu(32'h108, 32'h8000_0000, 32'd4, 1'b1, 4'd7, 5'd2);
    tick();
    chk("sra_result", out_result_o, 32'hF800_0000);

    drive_alu(32'h10C, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd8, 5'd3);
    tick();
    chk("slt_result", out_result_o, 32'd1);

    drive_alu(32'h110, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd9, 5'd3);
    fwd_b_i = 2'b10; wb_fwd_i = 32'd2;
    tick();
    chk("sltu_result", out_result_o, 32'd0);
    chk("sltu_rs2fwd", out_rs2_data_o, 32'd2);

    // Flush wins over a valid instruction
    drive_alu(32'h114, 32'd1, 32'd1, 1'b0, 4'd0, 5'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flushin_valid", 32'(out_valid_o), 32'd0);
    chk("flushin_pchold", out_pc_o, 32'h110);
    chk("flushin_rd", 32'(out_rd_add_o), 32'd0);

    run_mdu("mul", 2'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    run_mdu("mulhu", 2'd1, 32'hFFFF_FFFF, 32'd2, 32'h1);
    run_mdu("mul2", 2'd0, 32'h1234, 32'h5678, 32'h0626_0060);
    run_mdu("divu0", 2'd2, 32'd100, 32'd0, 32'hFFFF_FFFF);
    run_mdu("remu0", 2'd3, 32'd100, 32'd0, 32'd100);
    run_mdu("divu7", 2'd2, 32'd100, 32'd7, 32'd14);
    run_mdu("remu7", 2'd3, 32'd100, 32'd7, 32'd2);

    // Flush while the MDU is at iteration count 10
    start_mdu(2'd0, 32'd3, 32'd3);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("mflush_valid", 32'(out_valid_o), 32'd0);
    chk("mflush_ready", 32'(in_ready_o), 32'd1);
    chk("mflush_pchold", out_pc_o, 32'h200);
    vseen = 0;
    repeat (40) begin tick(); if (out_valid_o) vseen++; end
    chk("mflush_noresult", 32'(vseen), 32'd0);
    drive_alu(32'h300, 32'd20, 32'd22, 1'b0, 4'd0, 5'd5);
    tick();
    clear_in();
    chk("mflush_add_valid", 32'(out_valid_o), 32'd1);
    chk("mflush_add_result", out_result_o, 32'd42);

    // Reset in the middle of a divide
    start_mdu(2'd2, 32'd50, 32'd5);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", 32'(out_valid_o), 32'd0);
    chk("mrst_pc", out_pc_o, 32'd0);
    chk("mrst_result", out_result_o, 32'd0);
    chk("mrst_ready", 32'(in_ready_o), 32'd1);
    vseen = 0;
    repeat (40) begin tick(); if (out_valid_o) vseen++; end
    chk("mrst_noresult", 32'(vseen), 32'd0);

    // Three back-to-back ADDs
    drive_alu(32'h400, 32'd1, 32'd2, 1'b0, 4'd0, 5'd1);
    tick();
    chk("b2b0_valid", 32'(out_valid_o), 32'd1);
    chk("b2b0_result", out_result_o, 32'd3);
    drive_alu(32'h404, 32'd10, 32'd20, 1'b0, 4'd0, 5'd2);
    tick();
    chk("b2b1_valid", 32'(out_valid_o), 32'd1);
    chk("b2b1_result", out_result_o, 32'd30);
    drive_alu(32'h408, 32'hFFFF_FFFF, 32'd1, 1'b1, 4'd0, 5'd3);
    tick();
    chk("b2b2_valid", 32'(out_valid_o), 32'd1);
    chk("b2b2_result", out_result_o, 32'd0);
    chk("b2b2_zero", 32'(out_zero_o), 32'd1);
    clear_in();
    tick();
    chk("bubble_valid", 32'(out_valid_o), 32'd0);
    chk("bubble_regwrite", 32'(out_regwrite_o), 32'd0);
    chk("bubble_pchold", out_pc_o, 32'h408);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
